// File: rtl/scr1_dmem_arb.sv
// Round-robin arbiter for two data-memory requesters sharing one AHB bridge.
// An in-order ID FIFO routes each bridge response back to the requester that issued it.
package scr1_mem_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_arb
  import scr1_mem_pkg::*;
#(
  parameter int OUTST_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  output logic                 m0_req_ack,
  input  type_scr1_mem_cmd_e   m0_cmd,
  input  type_scr1_mem_width_e m0_width,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  output logic [31:0]          m0_rdata,
  output type_scr1_mem_resp_e  m0_resp,
  input  logic                 m1_req,
  output logic                 m1_req_ack,
  input  type_scr1_mem_cmd_e   m1_cmd,
  input  type_scr1_mem_width_e m1_width,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  output logic [31:0]          m1_rdata,
  output type_scr1_mem_resp_e  m1_resp,
  output logic                 dmem_req,
  input  logic                 dmem_req_ack,
  output type_scr1_mem_cmd_e   dmem_cmd,
  output type_scr1_mem_width_e dmem_width,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  type_scr1_mem_resp_e  dmem_resp,
  output logic                 err_orphan
);
  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTST_DEPTH + 1);

  logic                   rr_q, lock_vld_q, lock_id_q, err_q;
  logic [OUTST_DEPTH-1:0] fifo_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic sel, msel_req, can_issue, push, pop, resp_any, head;

  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTST_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A stalled grant owns the bridge until accepted, regardless of rr priority
  always_comb begin
    if (lock_vld_q)          sel = lock_id_q;
    else if (m0_req & m1_req) sel = rr_q;
    else                     sel = m1_req;
  end

  assign msel_req  = sel ? m1_req : m0_req;
  assign can_issue = (cnt_q < CNT_W'(OUTST_DEPTH)) & ~rst;
  assign dmem_req  = can_issue & msel_req;
  assign push      = dmem_req & dmem_req_ack;
  assign m0_req_ack = push & ~sel;
  assign m1_req_ack = push & sel;

  always_comb begin
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_WIDTH_BYTE;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (msel_req) begin
      dmem_cmd   = sel ? m1_cmd   : m0_cmd;
      dmem_width = sel ? m1_width : m0_width;
      dmem_addr  = sel ? m1_addr  : m0_addr;
      dmem_wdata = sel ? m1_wdata : m0_wdata;
    end
  end

  // Routing depends only on the registered FIFO head, never on request-side state
  assign resp_any = (dmem_resp != SCR1_MEM_RESP_NOTRDY);
  assign pop      = resp_any & ~rst & (cnt_q != '0);
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    m0_resp  = SCR1_MEM_RESP_NOTRDY;
    m1_resp  = SCR1_MEM_RESP_NOTRDY;
    m0_rdata = '0;
    m1_rdata = '0;
    if (pop) begin
      if (head) begin
        m1_resp  = dmem_resp;
        m1_rdata = dmem_rdata;
      end else begin
        m0_resp  = dmem_resp;
        m0_rdata = dmem_rdata;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
      err_q      <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_nxt(wr_ptr_q);
        rr_q             <= ~sel;
        lock_vld_q       <= 1'b0;
      end else if (dmem_req) begin
        lock_vld_q <= 1'b1;
        lock_id_q  <= sel;
      end
      if (pop) rd_ptr_q <= ptr_nxt(rd_ptr_q);
      cnt_q <= cnt_d;
      if (resp_any && cnt_q == '0) err_q <= 1'b1;
    end
  end

  assign err_orphan = err_q;
endmodule

// File: tb/tb_scr1_dmem_arb.sv
// Directed bench for scr1_dmem_arb: expected responses are queued at stimulus time
// and a negedge monitor matches them against whatever the DUT routes back.
module tb_scr1_dmem_arb;
  import scr1_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_req_ack, m1_req, m1_req_ack;
  type_scr1_mem_cmd_e   m0_cmd, m1_cmd, dmem_cmd;
  type_scr1_mem_width_e m0_width, m1_width, dmem_width;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  type_scr1_mem_resp_e  m0_resp, m1_resp, dmem_resp;
  logic dmem_req, dmem_req_ack, err_orphan;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic                id;
    type_scr1_mem_resp_e resp;
    logic [31:0]         rdata;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  scr1_dmem_arb #(.OUTST_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .err_orphan(err_orphan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input type_scr1_mem_resp_e r, input logic [31:0] d,
                         input logic id, input bit expect_it);
    exp_t e;
    dmem_resp  = r;
    dmem_rdata = d;
    if (expect_it) begin
      e.id = id; e.resp = r; e.rdata = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_idle_resp(input string name);
    chk({name, "_m0_resp"},  32'(m0_resp),  32'(SCR1_MEM_RESP_NOTRDY));
    chk({name, "_m1_resp"},  32'(m1_resp),  32'(SCR1_MEM_RESP_NOTRDY));
    chk({name, "_m0_rdata"}, m0_rdata, 32'h0);
    chk({name, "_m1_rdata"}, m1_rdata, 32'h0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && (m0_resp != SCR1_MEM_RESP_NOTRDY || m1_resp != SCR1_MEM_RESP_NOTRDY)) begin
      exp_t e;
      logic        aid;
      logic [31:0] ard;
      type_scr1_mem_resp_e ars;
      aid = (m1_resp != SCR1_MEM_RESP_NOTRDY);
      ars = aid ? m1_resp : m0_resp;
      ard = aid ? m1_rdata : m0_rdata;
      chk("resp_one_port", 32'(m0_resp != SCR1_MEM_RESP_NOTRDY && m1_resp != SCR1_MEM_RESP_NOTRDY), 32'h0);
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_id", 32'(aid), 32'(e.id));
        chk("resp_code", 32'(ars), 32'(e.resp));
        chk("resp_rdata", ard, e.rdata);
      end
    end
  end

  initial begin
    rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; dmem_req_ack = 1'b1;
    m0_cmd = SCR1_MEM_CMD_RD; m0_width = SCR1_MEM_WIDTH_WORD;
    m0_addr = 32'h0000_1000; m0_wdata = 32'h0;
    m1_cmd = SCR1_MEM_CMD_WR; m1_width = SCR1_MEM_WIDTH_HWORD;
    m1_addr = 32'h0000_2002; m1_wdata = 32'h5555_AAAA;
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 32'hFFFF_FFFF;

    // reset held with both requesting and a live bridge response
    repeat (2) begin
      cyc();
      chk("rst_dmem_req", 32'(dmem_req), 32'h0);
      chk("rst_m0_ack", 32'(m0_req_ack), 32'h0);
      chk("rst_m1_ack", 32'(m1_req_ack), 32'h0);
      chk_idle_resp("rst");
      chk("rst_err", 32'(err_orphan), 32'h0);
    end

    // round robin, one-cycle response latency
    rst = 1'b0; dmem_resp = SCR1_MEM_RESP_NOTRDY; dmem_rdata = 32'h0;
    #1;
    chk("rr0_addr", dmem_addr, 32'h0000_1000);
    chk("rr0_cmd", 32'(dmem_cmd), 32'(SCR1_MEM_CMD_RD));
    chk("rr0_m0_ack", 32'(m0_req_ack), 32'h1);
    chk("rr0_m1_ack", 32'(m1_req_ack), 32'h0);
    cyc();
    respond(SCR1_MEM_RESP_RDY_OK, 32'hA0, 1'b0, 1'b1); #1;
    chk("rr1_addr", dmem_addr, 32'h0000_2002);
    chk("rr1_cmd", 32'(dmem_cmd), 32'(SCR1_MEM_CMD_WR));
    chk("rr1_width", 32'(dmem_width), 32'(SCR1_MEM_WIDTH_HWORD));
    chk("rr1_wdata", dmem_wdata, 32'h5555_AAAA);
    chk("rr1_m1_ack", 32'(m1_req_ack), 32'h1);
    chk("rr1_m0_ack", 32'(m0_req_ack), 32'h0);
    chk("rr1_m1_resp", 32'(m1_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    cyc();
    respond(SCR1_MEM_RESP_RDY_OK, 32'hB1, 1'b1, 1'b1); #1;
    chk("rr2_addr", dmem_addr, 32'h0000_1000);
    cyc();
    respond(SCR1_MEM_RESP_RDY_OK, 32'hA2, 1'b0, 1'b1); #1;
    chk("rr3_addr", dmem_addr, 32'h0000_2002);
    cyc();
    m0_req = 1'b0; m1_req = 1'b0;
    respond(SCR1_MEM_RESP_RDY_OK, 32'hB3, 1'b1, 1'b1); #1;
    chk("idle_dmem_req", 32'(dmem_req), 32'h0);
    chk("idle_addr", dmem_addr, 32'h0);
    cyc();

    // stall lock on m1 while m0 tries to overtake
    dmem_resp = SCR1_MEM_RESP_NOTRDY; m1_req = 1'b1; dmem_req_ack = 1'b0; #1;
    chk("stall0_req", 32'(dmem_req), 32'h1);
    chk("stall0_addr", dmem_addr, 32'h0000_2002);
    chk("stall0_m1_ack", 32'(m1_req_ack), 32'h0);
    cyc();
    m0_req = 1'b1;
    repeat (2) begin
      #1;
      chk("stall_addr", dmem_addr, 32'h0000_2002);
      chk("stall_m0_ack", 32'(m0_req_ack), 32'h0);
      chk("stall_m1_ack", 32'(m1_req_ack), 32'h0);
      cyc();
    end
    dmem_req_ack = 1'b1; #1;
    chk("stall_rel_m1_ack", 32'(m1_req_ack), 32'h1);
    chk("stall_rel_m0_ack", 32'(m0_req_ack), 32'h0);
    cyc();
    #1;
    chk("after_stall_addr", dmem_addr, 32'h0000_1000);
    chk("after_stall_m0_ack", 32'(m0_req_ack), 32'h1);
    cyc();

    // two outstanding (m1 then m0): bridge blocked, response pops in same cycle
    respond(SCR1_MEM_RESP_RDY_OK, 32'hC1, 1'b1, 1'b1); #1;
    chk("full_dmem_req", 32'(dmem_req), 32'h0);
    chk("full_m0_ack", 32'(m0_req_ack), 32'h0);
    chk("full_m1_ack", 32'(m1_req_ack), 32'h0);
    cyc();
    // count 1: push m1 and pop older m0 together
    respond(SCR1_MEM_RESP_RDY_OK, 32'hC0, 1'b0, 1'b1); #1;
    chk("resume_dmem_req", 32'(dmem_req), 32'h1);
    chk("resume_addr", dmem_addr, 32'h0000_2002);
    chk("resume_m1_ack", 32'(m1_req_ack), 32'h1);
    cyc();
    m0_req = 1'b0; m1_req = 1'b0;
    respond(SCR1_MEM_RESP_RDY_OK, 32'hC2, 1'b1, 1'b1); #1;
    cyc();

    // orphan error response with nothing outstanding
    respond(SCR1_MEM_RESP_RDY_ER, 32'hDEAD, 1'b0, 1'b0); #1;
    chk_idle_resp("orphan");
    chk("orphan_err_pre", 32'(err_orphan), 32'h0);
    cyc();
    dmem_resp = SCR1_MEM_RESP_NOTRDY; #1;
    chk("orphan_err", 32'(err_orphan), 32'h1);
    m1_req = 1'b1; #1;
    chk("er_m1_ack", 32'(m1_req_ack), 32'h1);
    cyc();
    m1_req = 1'b0;
    respond(SCR1_MEM_RESP_RDY_ER, 32'hE1, 1'b1, 1'b1); #1;
    chk("er_m0_resp", 32'(m0_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    cyc();
    respond(SCR1_MEM_RESP_RDY_OK, 32'h99, 1'b0, 1'b0); #1;
    chk_idle_resp("er_drained");
    cyc();

    // reset mid-flight discards the outstanding ID
    dmem_resp = SCR1_MEM_RESP_NOTRDY; m0_req = 1'b1;
    cyc();
    m0_req = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    chk("midrst_err_clr", 32'(err_orphan), 32'h0);
    respond(SCR1_MEM_RESP_RDY_OK, 32'h77, 1'b0, 1'b0); #1;
    chk_idle_resp("midrst");
    cyc();
    dmem_resp = SCR1_MEM_RESP_NOTRDY; #1;
    chk("midrst_err_set", 32'(err_orphan), 32'h1);
    cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
